// File: rtl/axi_b_reorder_pkg.sv
// Shared constants, prefix-width rule and error causes for the B reorder block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package axi_b_reorder_pkg;

    localparam int unsigned RespWidth = 2;

    // A single prefix still needs one bit so the ID layout stays uniform.
    function automatic int unsigned prewidth(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef enum logic [1:0] {
        ERR_AW_PREFIX    = 2'd0,
        ERR_B_UNEXPECTED = 2'd1,
        ERR_B_COLLISION  = 2'd2
    } err_cause_e;

    localparam int unsigned NumErrCauses = 3;

endpackage

// File: rtl/axi_b_reorder_if.sv
// AW handshake plus B channel bundle between parallelizer, reorder block and controller.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both AW and B.
interface axi_b_reorder_if
    import axi_b_reorder_pkg::*;
#(
    parameter int unsigned PreIdWidth = 2,
    parameter int unsigned IdWidth    = 8,
    parameter int unsigned UserWidth  = 1
);
    logic                  aw_valid;
    logic                  aw_ready;
    logic [PreIdWidth-1:0] aw_prefix;
    logic                  b_valid;
    logic                  b_ready;
    logic [IdWidth-1:0]    b_id;
    logic [RespWidth-1:0]  b_resp;
    logic [UserWidth-1:0]  b_user;

    modport master (
        output aw_valid, aw_prefix, b_ready,
        input  aw_ready, b_valid, b_id, b_resp, b_user
    );

    modport slave (
        input  aw_valid, aw_prefix, b_ready,
        output aw_ready, b_valid, b_id, b_resp, b_user
    );
endinterface

// File: rtl/axi_b_reorder_slots.sv
// Per-prefix B response store: indexed write, head read, per-slot valid set/clear.
// Latency: a write is visible on the read port the cycle after the write edge.
// Backpressure: none internally; callers gate writes with chk_vld.
module axi_b_reorder_slots #(
    parameter int unsigned NumSlots   = 4,
    parameter int unsigned IdxWidth   = 2,
    parameter int unsigned EntryWidth = 11
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en,
    input  logic [IdxWidth-1:0]   wr_idx,
    input  logic [EntryWidth-1:0] wr_dat,
    input  logic [IdxWidth-1:0]   chk_idx,
    output logic                  chk_vld,
    input  logic                  clr_en,
    input  logic [IdxWidth-1:0]   rd_idx,
    output logic                  rd_vld,
    output logic [EntryWidth-1:0] rd_dat
);

    logic [NumSlots-1:0]   slot_vld_q;
    logic [EntryWidth-1:0] slot_dat_q [NumSlots];

    function automatic logic in_range(input logic [IdxWidth-1:0] idx);
        return 32'(idx) < NumSlots;
    endfunction

    // Prefixes beyond the slot count read as occupied so they are never accepted.
    assign chk_vld = in_range(chk_idx) ? slot_vld_q[chk_idx] : 1'b1;
    assign rd_vld  = in_range(rd_idx) & slot_vld_q[rd_idx];
    assign rd_dat  = slot_dat_q[rd_idx];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_vld_q <= '0;
        end else begin
            for (int i = 0; i < NumSlots; i++) begin
                // A capture into the slot being released wins over the clear.
                if (wr_en && (wr_idx == IdxWidth'(i))) begin
                    slot_vld_q[i] <= 1'b1;
                    slot_dat_q[i] <= wr_dat;
                end else if (clr_en && (rd_idx == IdxWidth'(i))) begin
                    slot_vld_q[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/axi_b_reorder.sv
// Caps outstanding writes at ParallelNum and returns B responses in AW issue order.
// Latency: AW is combinational pass-through; a captured B is released one cycle later at the earliest.
// Backpressure: AW stalls while full (unless the head B leaves that cycle); controller B stalls while its slot is occupied.
module axi_b_reorder
    import axi_b_reorder_pkg::*;
#(
    parameter int unsigned ParallelNum = 4,
    parameter int unsigned AxiIdWidth  = 6,
    parameter int unsigned UserWidth   = 1,
    localparam int unsigned PreIdWidth = prewidth(ParallelNum),
    localparam int unsigned IdWidth    = PreIdWidth + AxiIdWidth
) (
    input  logic             clk_i,
    input  logic             rst_i,
    axi_b_reorder_if.slave   slv,
    axi_b_reorder_if.master  mst,
    output logic             err_o
);

    typedef logic [PreIdWidth-1:0] preid_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [RespWidth-1:0] resp;
        logic [UserWidth-1:0] user;
    } b_entry_t;

    localparam int unsigned        OccWidth   = $clog2(ParallelNum + 1);
    localparam int unsigned        EntryWidth = $bits(b_entry_t);
    localparam logic [OccWidth-1:0] OccMax    = OccWidth'(ParallelNum);
    localparam preid_t             PtrLast    = preid_t'(ParallelNum - 1);

    function automatic preid_t ptr_inc(input preid_t p);
        return (p == PtrLast) ? '0 : p + preid_t'(1);
    endfunction

    logic [OccWidth-1:0]     occ_q, occ_d;
    preid_t                  iss_ptr_q, iss_ptr_d;
    preid_t                  head_ptr_q, head_ptr_d;
    logic                    err_q, err_d;
    logic [NumErrCauses-1:0] err_cause;

    preid_t                  b_pfx;
    logic                    pfx_vld;
    logic                    head_vld;
    logic [EntryWidth-1:0]   head_dat;
    b_entry_t                head_entry;
    b_entry_t                cap_entry;
    logic                    full;
    logic                    aw_hs;
    logic                    cap_hs;
    logic                    rel_hs;

    assign b_pfx  = mst.b_id[IdWidth-1 -: PreIdWidth];
    assign rel_hs = head_vld & slv.b_ready & ~rst_i;

    // A slot freed by this cycle's release may be reissued in the same cycle.
    assign full = (occ_q == OccMax) & ~rel_hs;

    assign mst.aw_valid  = slv.aw_valid & ~full & ~rst_i;
    assign mst.aw_prefix = iss_ptr_q;
    assign slv.aw_ready  = mst.aw_ready & ~full & ~rst_i;
    assign aw_hs         = slv.aw_valid & mst.aw_ready & ~full & ~rst_i;

    assign mst.b_ready = ~pfx_vld & ~rst_i;
    assign cap_hs      = mst.b_valid & mst.b_ready;
    assign cap_entry   = '{id: mst.b_id, resp: mst.b_resp, user: mst.b_user};

    assign head_entry  = b_entry_t'(head_dat);
    assign slv.b_valid = head_vld & ~rst_i;
    assign slv.b_id    = head_entry.id;
    assign slv.b_resp  = head_entry.resp;
    assign slv.b_user  = head_entry.user;

    assign err_o = err_q & ~rst_i;

    axi_b_reorder_slots #(
        .NumSlots   (ParallelNum),
        .IdxWidth   (PreIdWidth),
        .EntryWidth (EntryWidth)
    ) i_slots (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .wr_en   (cap_hs),
        .wr_idx  (b_pfx),
        .wr_dat  (cap_entry),
        .chk_idx (b_pfx),
        .chk_vld (pfx_vld),
        .clr_en  (rel_hs),
        .rd_idx  (head_ptr_q),
        .rd_vld  (head_vld),
        .rd_dat  (head_dat)
    );

    always_comb begin
        err_cause                   = '0;
        err_cause[ERR_AW_PREFIX]    = aw_hs & (slv.aw_prefix != iss_ptr_q);
        err_cause[ERR_B_UNEXPECTED] = cap_hs & (occ_q == '0);
        err_cause[ERR_B_COLLISION]  = cap_hs & rel_hs & (b_pfx == head_ptr_q);
    end

    always_comb begin
        occ_d      = occ_q;
        iss_ptr_d  = iss_ptr_q;
        head_ptr_d = head_ptr_q;
        err_d      = err_q | (|err_cause);

        if (aw_hs) iss_ptr_d = ptr_inc(iss_ptr_q);
        if (rel_hs) head_ptr_d = ptr_inc(head_ptr_q);

        // Releases of unexpected Bs (occ already 0) must not wrap the counter.
        case ({aw_hs, rel_hs})
            2'b10: occ_d = occ_q + OccWidth'(1);
            2'b01: if (occ_q != '0) occ_d = occ_q - OccWidth'(1);
            2'b11: if (occ_q == '0) occ_d = OccWidth'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            occ_q      <= '0;
            iss_ptr_q  <= '0;
            head_ptr_q <= '0;
            err_q      <= 1'b0;
        end else begin
            occ_q      <= occ_d;
            iss_ptr_q  <= iss_ptr_d;
            head_ptr_q <= head_ptr_d;
            err_q      <= err_d;
        end
    end

    a_err_sticky: assert property (@(posedge clk_i) disable iff (rst_i) (|err_cause) |=> err_q);
    a_occ_range:  assert property (@(posedge clk_i) disable iff (rst_i) occ_q <= OccMax);
    a_head_range: assert property (@(posedge clk_i) disable iff (rst_i) head_ptr_q <= PtrLast);

endmodule

// File: tb/tb_axi_b_reorder.sv
// Scoreboard bench for axi_b_reorder: AW order defines expected B release order.
// Latency: checks first-B release one cycle after capture and same-cycle release/AW when full.
// Backpressure: holds slv B ready low to check payload stability and continued capture.
module tb_axi_b_reorder;
    import axi_b_reorder_pkg::*;

    localparam int unsigned ParallelNum = 4;
    localparam int unsigned AxiIdWidth  = 6;
    localparam int unsigned UserWidth   = 1;
    localparam int unsigned PreIdWidth  = prewidth(ParallelNum);
    localparam int unsigned IdWidth     = PreIdWidth + AxiIdWidth;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [RespWidth-1:0] resp;
        logic [UserWidth-1:0] user;
    } b_entry_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic err_o;

    always #5 clk_i = ~clk_i;

    axi_b_reorder_if #(.PreIdWidth(PreIdWidth), .IdWidth(IdWidth), .UserWidth(UserWidth)) slv_if ();
    axi_b_reorder_if #(.PreIdWidth(PreIdWidth), .IdWidth(IdWidth), .UserWidth(UserWidth)) mst_if ();

    axi_b_reorder #(
        .ParallelNum (ParallelNum),
        .AxiIdWidth  (AxiIdWidth),
        .UserWidth   (UserWidth)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .slv   (slv_if),
        .mst   (mst_if),
        .err_o (err_o)
    );

    int       checks = 0;
    int       errors = 0;
    int       tb_iss = 0;
    b_entry_t exp_q [$];
    b_entry_t pend [ParallelNum];
    b_entry_t mon_e;
    b_entry_t bp_e;
    b_entry_t new_e;
    int       bp_ord [3];

    task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        slv_if.aw_valid  = 1'b0;
        slv_if.aw_prefix = '0;
        slv_if.b_ready   = 1'b1;
        mst_if.aw_ready  = 1'b1;
        mst_if.b_valid   = 1'b0;
        mst_if.b_id      = '0;
        mst_if.b_resp    = '0;
        mst_if.b_user    = '0;
    endtask

    task automatic do_reset();
        rst_i           = 1'b1;
        slv_if.aw_valid = 1'b1;
        mst_if.aw_ready = 1'b1;
        mst_if.b_valid  = 1'b1;
        #2;
        chk_val("rst_slv_aw_ready", 32'(slv_if.aw_ready), 0);
        chk_val("rst_mst_aw_valid", 32'(mst_if.aw_valid), 0);
        chk_val("rst_mst_b_ready", 32'(mst_if.b_ready), 0);
        chk_val("rst_slv_b_valid", 32'(slv_if.b_valid), 0);
        chk_val("rst_err", 32'(err_o), 0);
        step();
        rst_i = 1'b0;
        idle_inputs();
        exp_q.delete();
        tb_iss = 0;
        #2;
        chk_val("post_rst_occ", 32'(dut.occ_q), 0);
        chk_val("post_rst_err", 32'(err_o), 0);
        chk_val("post_rst_slv_b_valid", 32'(slv_if.b_valid), 0);
    endtask

    // Payload id carries the slot the DUT will assign, i.e. the bench's issue pointer.
    task automatic send_aw(input logic [PreIdWidth-1:0] pfx, input int low, input int resp, input int user);
        int       n = 0;
        b_entry_t pl;
        pl.id            = {PreIdWidth'(tb_iss), AxiIdWidth'(low)};
        pl.resp          = RespWidth'(resp);
        pl.user          = UserWidth'(user);
        slv_if.aw_valid  = 1'b1;
        slv_if.aw_prefix = pfx;
        #2;
        while (slv_if.aw_ready !== 1'b1 && n < 50) begin
            step();
            #2;
            n++;
        end
        if (n >= 50) begin
            chk_val("aw_hs_timeout", 32'(slv_if.aw_ready), 1);
        end else begin
            exp_q.push_back(pl);
            pend[tb_iss] = pl;
            tb_iss       = (tb_iss + 1) % ParallelNum;
        end
        step();
        slv_if.aw_valid = 1'b0;
    endtask

    task automatic send_aw_rand();
        send_aw(PreIdWidth'(tb_iss), $urandom_range(0, 63), $urandom_range(0, 3), $urandom_range(0, 1));
    endtask

    task automatic send_b(input int slot);
        int n = 0;
        mst_if.b_valid = 1'b1;
        mst_if.b_id    = pend[slot].id;
        mst_if.b_resp  = pend[slot].resp;
        mst_if.b_user  = pend[slot].user;
        #2;
        chk_val("mst_b_ready", 32'(mst_if.b_ready), 1);
        while (mst_if.b_ready !== 1'b1 && n < 50) begin
            step();
            #2;
            n++;
        end
        if (n >= 50) chk_val("b_cap_timeout", 32'(mst_if.b_ready), 1);
        step();
        mst_if.b_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        slv_if.b_ready = 1'b1;
        while (exp_q.size() != 0 && n < 100) begin
            step();
            n++;
        end
        #2;
        chk_val("drain_left", 32'(exp_q.size()), 0);
        chk_val("drain_occ", 32'(dut.occ_q), 0);
    endtask

    always @(negedge clk_i) begin
        if (!rst_i && slv_if.b_valid === 1'b1 && slv_if.b_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk_val("sb_unexpected_b", 32'(slv_if.b_valid), 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk_val("sb_b_id", 32'(slv_if.b_id), 32'(mon_e.id));
                chk_val("sb_b_resp", 32'(slv_if.b_resp), 32'(mon_e.resp));
                chk_val("sb_b_user", 32'(slv_if.b_user), 32'(mon_e.user));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst_i = 1'b1;
        repeat (2) step();
        do_reset();

        // Single in-order write, held at slv side to observe first-cycle validity.
        slv_if.b_ready = 1'b0;
        send_aw(PreIdWidth'(0), 'h05, 0, 0);
        chk_val("t1_occ", 32'(dut.occ_q), 1);
        mst_if.b_valid = 1'b1;
        mst_if.b_id    = pend[0].id;
        mst_if.b_resp  = pend[0].resp;
        mst_if.b_user  = pend[0].user;
        #2;
        chk_val("t1_no_comb_path", 32'(slv_if.b_valid), 0);
        chk_val("t1_mst_b_ready", 32'(mst_if.b_ready), 1);
        step();
        mst_if.b_valid = 1'b0;
        #2;
        chk_val("t1_b_valid_next", 32'(slv_if.b_valid), 1);
        chk_val("t1_b_id", 32'(slv_if.b_id), 32'h05);
        slv_if.b_ready = 1'b1;
        step();
        #2;
        chk_val("t1_occ_back", 32'(dut.occ_q), 0);
        chk_val("t1_b_valid_drop", 32'(slv_if.b_valid), 0);

        // Out-of-order completion: 2,0,3,1 must release as 0,1,2,3.
        do_reset();
        repeat (4) send_aw_rand();
        chk_val("t2_occ_full", 32'(dut.occ_q), 4);
        send_b(2);
        send_b(0);
        send_b(3);
        send_b(1);
        drain();

        // Full throttle, then same-cycle release and reissue of slot 0.
        repeat (4) send_aw_rand();
        slv_if.aw_valid  = 1'b1;
        slv_if.aw_prefix = PreIdWidth'(tb_iss);
        #2;
        chk_val("t3_full_slv_aw_ready", 32'(slv_if.aw_ready), 0);
        chk_val("t3_full_mst_aw_valid", 32'(mst_if.aw_valid), 0);
        mst_if.b_valid = 1'b1;
        mst_if.b_id    = pend[0].id;
        mst_if.b_resp  = pend[0].resp;
        mst_if.b_user  = pend[0].user;
        step();
        mst_if.b_valid = 1'b0;
        #2;
        chk_val("t3_head_valid", 32'(slv_if.b_valid), 1);
        chk_val("t3_bypass_aw_ready", 32'(slv_if.aw_ready), 1);
        chk_val("t3_bypass_mst_aw_valid", 32'(mst_if.aw_valid), 1);
        new_e.id   = {PreIdWidth'(0), AxiIdWidth'(6'h2a)};
        new_e.resp = 2'b10;
        new_e.user = 1'b1;
        exp_q.push_back(new_e);
        pend[0] = new_e;
        tb_iss  = 1;
        step();
        slv_if.aw_valid = 1'b0;
        #2;
        chk_val("t3_occ_stays_full", 32'(dut.occ_q), 4);
        chk_val("t3_no_err", 32'(err_o), 0);
        send_b(1);
        send_b(2);
        send_b(3);
        send_b(0);
        drain();

        // Backpressure: head held for 10 cycles while other slots fill.
        repeat (4) send_aw_rand();
        slv_if.b_ready = 1'b0;
        send_b(1);
        bp_e   = exp_q[0];
        bp_ord = '{3, 0, 2};
        for (int i = 0; i < 10; i++) begin
            if (i < 3) begin
                mst_if.b_valid = 1'b1;
                mst_if.b_id    = pend[bp_ord[i]].id;
                mst_if.b_resp  = pend[bp_ord[i]].resp;
                mst_if.b_user  = pend[bp_ord[i]].user;
            end else begin
                mst_if.b_valid = 1'b0;
            end
            #2;
            if (i < 3) chk_val("t4_capture_ready", 32'(mst_if.b_ready), 1);
            chk_val("t4_hold_valid", 32'(slv_if.b_valid), 1);
            chk_val("t4_hold_id", 32'(slv_if.b_id), 32'(bp_e.id));
            chk_val("t4_hold_resp", 32'(slv_if.b_resp), 32'(bp_e.resp));
            step();
        end
        chk_val("t4_occ", 32'(dut.occ_q), 4);
        drain();

        // Errors: wrong AW prefix is sticky; unexpected B is flagged and stored.
        do_reset();
        send_aw(PreIdWidth'(1), 3, 0, 0);
        #2;
        chk_val("t5_aw_prefix_err", 32'(err_o), 1);
        repeat (5) step();
        chk_val("t5_err_sticky", 32'(err_o), 1);
        do_reset();
        mst_if.b_valid = 1'b1;
        mst_if.b_id    = {PreIdWidth'(2), AxiIdWidth'(6'h11)};
        #2;
        chk_val("t5_unexp_b_ready", 32'(mst_if.b_ready), 1);
        step();
        mst_if.b_valid = 1'b0;
        #2;
        chk_val("t5_unexp_b_err", 32'(err_o), 1);
        chk_val("t5_unexp_b_stored", 32'(mst_if.b_ready), 0);

        // Reset with three writes outstanding and one slot filled.
        do_reset();
        slv_if.b_ready = 1'b0;
        repeat (3) send_aw_rand();
        send_b(1);
        chk_val("t6_occ_before", 32'(dut.occ_q), 3);
        do_reset();
        mst_if.b_id = pend[1].id;
        #2;
        chk_val("t6_slot_cleared", 32'(mst_if.b_ready), 1);
        send_aw(PreIdWidth'(0), 'h21, 1, 1);
        chk_val("t6_first_prefix_ok", 32'(err_o), 0);
        send_b(0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
